// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and default widths for the
// command-to-APB master bridge.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: ACCESS wait-cycle counter for the bridge timeout.
// Only built when APB_CMD_MASTER_TIMEOUT_EN is defined.
`ifdef APB_CMD_MASTER_TIMEOUT_EN
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expired = (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding valid/ready command to APB bridge.
// Optional ACCESS timeout via APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_t        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timed_out;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk   (pclk),
        .preset (preset),
        .clear  (state_q == SETUP),
        .inc    ((state_q == ACCESS) && !pready),
        .expired(timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE) && !preset;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A completing slave takes priority over the timeout.
                if (pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timed_out) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed plus random transfers checked against a
// per-transfer timeline model (setup, access length, response, hold).
module tb_apb_cmd_master;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 16;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata = '0;
    logic       pready = 1'b0;
    logic       pslverr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 pclk = ~pclk;

    apb_cmd_master dut (
        .pclk     (pclk),
        .preset   (preset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".psel"}, psel, 0);
        chk({tag, ".penable"}, penable, 0);
        chk({tag, ".pwrite"}, pwrite, 0);
        chk({tag, ".paddr"}, paddr, 0);
        chk({tag, ".pwdata"}, pwdata, 0);
        chk({tag, ".rsp_valid"}, rsp_valid, 0);
        chk({tag, ".rsp_rdata"}, rsp_rdata, 0);
        chk({tag, ".rsp_err"}, rsp_err, 0);
    endtask

    // One transfer: slave stalls 'waits' ACCESS cycles, response held
    // 'hold' cycles by rsp_ready = 0 before the consumer takes it.
    task automatic run_txn(input logic wr, input logic [7:0] addr,
                           input logic [7:0] wd, input int waits,
                           input logic [7:0] rd, input logic err,
                           input int hold);
        bit         abort;
        int         acc;
        logic [7:0] exp_rd;
        logic       exp_err;
        abort   = TMO_EN && (waits > TMO);
        acc     = abort ? TMO + 1 : waits + 1;
        exp_rd  = (wr || abort) ? 8'h00 : rd;
        exp_err = abort ? 1'b1 : err;

        chk("idle.cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        tick;
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
        chk("setup.psel", psel, 1);
        chk("setup.penable", penable, 0);
        chk("setup.paddr", paddr, addr);
        chk("setup.pwrite", pwrite, wr);
        chk("setup.pwdata", pwdata, wd);
        chk("setup.cmd_ready", cmd_ready, 0);
        chk("setup.rsp_valid", rsp_valid, 0);
        tick;
        for (int k = 0; k < acc; k++) begin
            chk("access.psel", psel, 1);
            chk("access.penable", penable, 1);
            chk("access.paddr", paddr, addr);
            chk("access.pwrite", pwrite, wr);
            chk("access.pwdata", pwdata, wd);
            chk("access.rsp_valid", rsp_valid, 0);
            chk("access.cmd_ready", cmd_ready, 0);
            pready  = !abort && (k == waits);
            prdata  = (k == waits) ? rd : 8'($urandom);
            pslverr = (k == waits) ? err : 1'($urandom);
            tick;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 8'($urandom);
        for (int j = 0; j <= hold; j++) begin
            chk("resp.rsp_valid", rsp_valid, 1);
            chk("resp.rsp_rdata", rsp_rdata, exp_rd);
            chk("resp.rsp_err", rsp_err, exp_err);
            chk("resp.psel", psel, 0);
            chk("resp.penable", penable, 0);
            chk("resp.cmd_ready", cmd_ready, 0);
            rsp_ready = (j == hold);
            if (j == hold) cmd_valid = 1'b0;
            tick;
        end
        rsp_ready = 1'b0;
        chk("after.rsp_valid", rsp_valid, 0);
        chk("after.psel", psel, 0);
        chk("after.cmd_ready", cmd_ready, 1);
    endtask

    task automatic reset_mid_access;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h33;
        cmd_wdata = 8'h44;
        pready    = 1'b0;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        chk("mid.penable", penable, 1);
        preset = 1'b1;
        tick;
        chk_reset_vals("mid_rst");
        chk("mid_rst.cmd_ready", cmd_ready, 0);
        preset = 1'b0;
        #1;
        chk("mid_post.cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("mid_post.rsp_valid", rsp_valid, 0);
            chk("mid_post.psel", psel, 0);
        end
    endtask

    initial begin
        preset = 1'b1;
        tick;
        tick;
        chk_reset_vals("reset");
        chk("reset.cmd_ready", cmd_ready, 0);
        preset = 1'b0;
        #1;
        chk("post_reset.cmd_ready", cmd_ready, 1);

        run_txn(1'b1, 8'h00, 8'h05, 0, 8'hEE, 1'b0, 0);
        run_txn(1'b0, 8'h01, 8'h00, 3, 8'h5A, 1'b0, 0);
        run_txn(1'b1, 8'h07, 8'h11, 0, 8'h99, 1'b1, 0);
        run_txn(1'b0, 8'h02, 8'h00, 1, 8'hC3, 1'b0, 5);
        run_txn(1'b0, 8'h03, 8'h00, 40, 8'hAA, 1'b0, 0);
        run_txn(1'b0, 8'h04, 8'h00, TMO, 8'h3C, 1'b0, 0);
        run_txn(1'b1, 8'h05, 8'h77, TMO - 1, 8'h00, 1'b1, 1);

        reset_mid_access;

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5),
                    8'($urandom), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Command-to-APB master bridge that sits directly upstream of the 8-bit timer's APB slave port. It accepts single read/write commands over a valid/ready interface and converts each into a compliant APB SETUP/ACCESS transfer. It waits on `pready` and returns read data and error status over a valid/ready response channel. Its APB outputs connect one-to-one to the timer's `psel/penable/pwrite/paddr/pwdata` inputs, and its APB inputs take the timer's `prdata/pready/pslverr`.

## Interface
- `ADDR_W`, 8, APB address width.
- `DATA_W`, 8, APB data width.
- `TIMEOUT_CYCLES`, 16, maximum ACCESS wait cycles before abort; only used with the timeout feature. Legal range 1..255.

- `pclk` in 1: the only clock; all logic on its rising edge.
- `preset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when both `rsp_valid` and `rsp_ready` are high.
- `rsp_rdata` out DATA_W: read data; 0 for writes and aborted transfers.
- `rsp_err` out 1: `pslverr` was sampled, or the transfer timed out.
- `psel`, `penable`, `pwrite` out 1: APB controls.
- `paddr` out ADDR_W: APB address.
- `pwdata` out DATA_W: APB write data.
- `prdata` in DATA_W: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB slave error.

## Operation
- FSM states are IDLE, SETUP, ACCESS, RESP. All APB and response outputs are registered.
- **IDLE:**
  - `cmd_ready` = 1 (forced 0 while `preset` is high).
  - On handshake, latch write/addr/wdata into `pwrite/paddr/pwdata`, set `psel` = 1, and go to SETUP.
- **SETUP:** `psel` = 1, `penable` = 0. Always advances to ACCESS after one cycle, with `penable` = 1.
- **ACCESS:**
  - Holds while `pready` = 0.
  - When `pready` = 1:
    - Capture `rsp_rdata` = `prdata` for a read, or 0 for a write.
    - Capture `rsp_err` = `pslverr`.
    - Clear `psel` and `penable`, set `rsp_valid` = 1, and go to RESP.
- **RESP:**
  - Response outputs hold stable until `rsp_ready` = 1.
  - Then `rsp_valid` = 0 and the FSM returns to IDLE.
  - `cmd_ready` is 0 in every state other than IDLE, so only one transfer is outstanding at a time.
- **Stability:** `paddr`, `pwrite` and `pwdata` stay constant from SETUP through the final ACCESS cycle. They keep their last value in IDLE and RESP.
- **Reset values:**
  - FSM state: IDLE.
  - Outputs `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`: 0.
  - `cmd_ready`: 0 during reset, 1 in the first cycle after reset deasserts.
- **Reset mid-transfer:** at the next edge with `preset` = 1, every state returns to reset values. `psel` drops immediately, and no response is issued for the aborted command.

## Timing
- Command handshake in cycle N:
  - SETUP (`psel` = 1) in N+1.
  - ACCESS (`penable` = 1) in N+2.
  - With zero wait states, `pready` is sampled in N+2 and `rsp_valid` = 1 in N+3.
- Each wait cycle (`pready` = 0) adds exactly one cycle.
- If the response handshakes in cycle M, the FSM is in IDLE in M+1 and `cmd_ready` = 1 in M+1. Best-case throughput is one command per 4 cycles.
- `psel` and `penable` deassert in the cycle that `rsp_valid` asserts.

## Configuration
- `APB_CMD_MASTER_TIMEOUT_EN`:
  - **Defined:** a wait counter clears on entry to ACCESS and increments on each ACCESS cycle with `pready` = 0. When the counter equals `TIMEOUT_CYCLES`, the FSM aborts:
    - `psel` and `penable` go to 0.
    - `rsp_err` = 1, `rsp_rdata` = 0.
    - The FSM goes to RESP.
    - If `pready` = 1 in the same cycle, the normal completion wins.
  - **Undefined:** no counter is built, and ACCESS waits for `pready` indefinitely.

## Structure
- Shared package `apb_pkg`:
  - FSM state enum `apb_state_t` {IDLE, SETUP, ACCESS, RESP}.
  - Default width constants `APB_ADDR_W` = 8 and `APB_DATA_W` = 8.
- One sub-module, `apb_wait_timer`: the timeout counter, compiled only under `APB_CMD_MASTER_TIMEOUT_EN`. Inputs are `pclk`, `preset`, `clear` and `inc`; the output is `expired`.
- FSM and datapath stay in `apb_cmd_master`.

## Test plan
- **Zero-wait write:** command write `0x00` ← `0x05`, slave `pready` = 1 immediately.
  - Expect `psel` in N+1 and `penable` in N+2 with `paddr` = `0x00`, `pwdata` = `0x05`, `pwrite` = 1.
  - Expect `rsp_valid` in N+3 with `rsp_rdata` = 0, `rsp_err` = 0.
- **Wait-state read:** read `0x01`, slave holds `pready` = 0 for 3 cycles, then returns `0x5A`.
  - Expect ACCESS to last 4 cycles with address stable, then `rsp_rdata` = `0x5A` and `rsp_valid` in N+6.
- **Slave error:** write to `0x07`, slave returns `pslverr` = 1 with `pready` = 1.
  - Expect `rsp_err` = 1, `rsp_rdata` = 0.
- **Response backpressure:** hold `rsp_ready` = 0 for 5 cycles.
  - Expect the response to stay stable, `cmd_ready` = 0 and `psel` = 0 throughout.
  - After the handshake, expect `cmd_ready` = 1 in the next cycle.
- **Timeout** (macro defined, `TIMEOUT_CYCLES` = 16): `pready` stuck at 0.
  - Expect abort after the 16th wait cycle: `psel` = 0, `rsp_err` = 1, `rsp_rdata` = 0.
  - Repeat with `pready` = 1 on exactly the 16th wait cycle; expect normal completion.
- **Reset mid-ACCESS:** assert `preset` for 1 cycle while `pready` = 0.
  - Expect all outputs at reset values in the next cycle and no `rsp_valid`.
  - Expect `cmd_ready` = 1 after reset deasserts.
